// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, Gray export, read-pointer sync and full/level/overflow flags
// of the async FIFO.
module fifo_wptr_full #(
   parameter int ADDR_W    = 3,
   parameter int AF_THRESH = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W:0]   rptr_gray,
   input  logic              clr_ovf,
   output logic              wr_ok,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr_gray,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   level,
   output logic              overflow
);
   logic [ADDR_W:0] r_wbin, r_wgray, r_rq1, r_rq2, r_level;
   logic            r_full, r_af, r_ovf;
   logic [ADDR_W:0] w_wbin_next, w_wgray_next, w_rbin_s, w_level_next;
   logic            w_full_next;

   assign wr_ok        = wr_en && !r_full;
   assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, wr_ok};
   assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
   assign w_level_next = w_wbin_next - w_rbin_s;
   // Full when the write pointer is exactly one lap ahead of the synced read pointer.
   assign w_full_next  = w_wgray_next == {~r_rq2[ADDR_W:ADDR_W-1], r_rq2[ADDR_W-2:0]};

   for (genvar i = 0; i <= ADDR_W; i++) begin : g_g2b
      assign w_rbin_s[i] = ^r_rq2[ADDR_W:i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_rq1   <= '0;
         r_rq2   <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_af    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_next;
         r_wgray <= w_wgray_next;
         r_rq1   <= rptr_gray;
         r_rq2   <= r_rq1;
         r_level <= w_level_next;
         r_full  <= w_full_next;
         r_af    <= w_level_next >= (ADDR_W+1)'(AF_THRESH);
         r_ovf   <= (wr_en && r_full) || (r_ovf && !clr_ovf);
      end
   end

   assign waddr       = r_wbin[ADDR_W-1:0];
   assign wptr_gray   = r_wgray;
   assign full        = r_full;
   assign almost_full = r_af;
   assign level       = r_level;
   assign overflow    = r_ovf;
endmodule
